// File: rtl/asteroid_collision_tracker.sv
// rtl/asteroid_collision_tracker.sv - per-pixel collision bus plus per-frame stage FSM, hit count, score and survival timer
module asteroid_collision_tracker #(
    parameter int ASTEROIDS_AMOUNT = 20,
    parameter int HIT_SCORE        = 10,
    parameter int STAGE_FRAMES     = 1800,
    parameter int SCORE_WIDTH      = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    startOfFrame,
    input  logic                                    start,
    input  logic                                    asteroidsDR,
    input  logic                                    missileDR,
    input  logic                                    playerDR,
    input  logic                                    borderDR,
    output logic [5:0]                              collision,
    output logic                                    stage_active,
    output logic                                    stage_done,
    output logic                                    stage_won,
    output logic [$clog2(ASTEROIDS_AMOUNT+1)-1:0]   destroyed_count,
    output logic [SCORE_WIDTH-1:0]                  score,
    output logic [$clog2(STAGE_FRAMES+1)-1:0]       frames_left
);

    localparam int CNT_W = $clog2(ASTEROIDS_AMOUNT + 1);
    localparam int FRM_W = $clog2(STAGE_FRAMES + 1);
    localparam int SUM_W = SCORE_WIDTH + 1;

    localparam logic [CNT_W-1:0]       CNT_TARGET = CNT_W'(ASTEROIDS_AMOUNT);
    localparam logic [FRM_W-1:0]       FRM_RELOAD = FRM_W'(STAGE_FRAMES);
    localparam logic [SUM_W-1:0]       HIT_ADD    = SUM_W'(HIT_SCORE);
    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = {SCORE_WIDTH{1'b1}};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PLAYING = 2'd1;
    localparam logic [1:0] S_CLEARED = 2'd2;
    localparam logic [1:0] S_FAILED  = 2'd3;

    logic [1:0]             state_q,  state_d;
    logic                   hit_q,    hit_d;
    logic                   dead_q,   dead_d;
    logic [CNT_W-1:0]       count_q,  count_d;
    logic [SCORE_WIDTH-1:0] score_q,  score_d;
    logic [FRM_W-1:0]       frames_q, frames_d;
    logic                   active_q, active_d;
    logic                   done_q,   done_d;
    logic                   won_q,    won_d;

    logic [SUM_W-1:0]       score_sum;
    logic [CNT_W-1:0]       count_inc;

    assign collision = {missileDR   & playerDR,
                        asteroidsDR & borderDR,
                        playerDR    & borderDR,
                        missileDR   & borderDR,
                        asteroidsDR & playerDR,
                        asteroidsDR & missileDR};

    assign score_sum = {1'b0, score_q} + HIT_ADD;
    assign count_inc = count_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        hit_d    = 1'b0;
        dead_d   = 1'b0;
        count_d  = count_q;
        score_d  = score_q;
        frames_d = frames_q;

        if (state_q == S_PLAYING) begin
            hit_d  = hit_q  | collision[0];
            dead_d = dead_q | collision[1];
            if (startOfFrame) begin
                // The startOfFrame cycle itself belongs to the new frame.
                hit_d  = collision[0];
                dead_d = collision[1];
                if (dead_q) begin
                    state_d = S_FAILED;
                end else if (hit_q) begin
                    if (count_q != CNT_TARGET) begin
                        count_d = count_inc;
                    end
                    score_d = score_sum[SCORE_WIDTH] ? SCORE_MAX : score_sum[SCORE_WIDTH-1:0];
                    if (count_inc == CNT_TARGET) begin
                        state_d = S_CLEARED;
                    end
                end else if (frames_q <= FRM_W'(1)) begin
                    frames_d = '0;
                    state_d  = S_CLEARED;
                end else begin
                    frames_d = frames_q - FRM_W'(1);
                end
            end
        end

        if (state_d != S_PLAYING) begin
            hit_d  = 1'b0;
            dead_d = 1'b0;
        end

        if (start) begin
            state_d  = S_PLAYING;
            hit_d    = 1'b0;
            dead_d   = 1'b0;
            count_d  = '0;
            score_d  = '0;
            frames_d = FRM_RELOAD;
        end

        active_d = (state_d == S_PLAYING);
        won_d    = (state_d == S_CLEARED);
        // Only PLAYING can reach an end state, so this fires once per stage.
        done_d   = (state_q == S_PLAYING) &&
                   ((state_d == S_CLEARED) || (state_d == S_FAILED));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            hit_q    <= 1'b0;
            dead_q   <= 1'b0;
            count_q  <= '0;
            score_q  <= '0;
            frames_q <= FRM_RELOAD;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            won_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hit_q    <= hit_d;
            dead_q   <= dead_d;
            count_q  <= count_d;
            score_q  <= score_d;
            frames_q <= frames_d;
            active_q <= active_d;
            done_q   <= done_d;
            won_q    <= won_d;
        end
    end

    assign stage_active    = active_q;
    assign stage_done      = done_q;
    assign stage_won       = won_q;
    assign destroyed_count = count_q;
    assign score           = score_q;
    assign frames_left     = frames_q;

endmodule

// File: tb/tb_asteroid_collision_tracker.sv
// tb/tb_asteroid_collision_tracker.sv - scoreboard bench for asteroid_collision_tracker
module tb_asteroid_collision_tracker;

    localparam int AMT = 20;
    localparam int HS  = 10;
    localparam int SF  = 4;
    localparam int SW  = 16;
    localparam int CW  = $clog2(AMT + 1);
    localparam int FW  = $clog2(SF + 1);
    localparam int OW  = 3 + CW + SW + FW;

    logic clk = 1'b0;
    logic reset = 1'b1, startOfFrame = 1'b0, start = 1'b0;
    logic asteroidsDR = 1'b0, missileDR = 1'b0, playerDR = 1'b0, borderDR = 1'b0;
    logic [5:0]    collision;
    logic          stage_active, stage_done, stage_won;
    logic [CW-1:0] destroyed_count;
    logic [SW-1:0] score;
    logic [FW-1:0] frames_left;

    int n_tests = 0;
    int n_fail  = 0;

    logic [OW-1:0] exp_q[$];
    logic [5:0]    col_q[$];
    logic [OW-1:0] e;
    logic [5:0]    ec;

    asteroid_collision_tracker #(
        .ASTEROIDS_AMOUNT(AMT), .HIT_SCORE(HS), .STAGE_FRAMES(SF), .SCORE_WIDTH(SW)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start(start),
        .asteroidsDR(asteroidsDR), .missileDR(missileDR), .playerDR(playerDR), .borderDR(borderDR),
        .collision(collision), .stage_active(stage_active), .stage_done(stage_done),
        .stage_won(stage_won), .destroyed_count(destroyed_count), .score(score),
        .frames_left(frames_left)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] mk(input int act, done, won, cnt, sc, fl);
        return {act[0], done[0], won[0], cnt[CW-1:0], sc[SW-1:0], fl[FW-1:0]};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {stage_active, stage_done, stage_won, destroyed_count, score, frames_left};
    endfunction

    task automatic tick(input logic rst, st, sof, a, m, p, b);
        @(negedge clk);
        reset = rst; start = st; startOfFrame = sof;
        asteroidsDR = a; missileDR = m; playerDR = p; borderDR = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, SF));
        tick(0, 0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_state: got %h expected %h", obs(), e); end
    endtask

    task automatic test_collision_idle();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            asteroidsDR = i[3]; missileDR = i[2]; playerDR = i[1]; borderDR = i[0];
            col_q.push_back({i[2] & i[1], i[3] & i[0], i[1] & i[0], i[2] & i[0], i[3] & i[1], i[3] & i[2]});
            #1;
            ec = col_q.pop_front(); n_tests++;
            if (collision !== ec) begin n_fail++; $display("FAIL collision_%0d: got %b expected %b", i, collision, ec); end
        end
        for (int f = 0; f < 3; f++) begin
            tick(0, 0, 1, 1, 1, 0, 0);
            tick(0, 0, 0, 1, 1, 0, 0);
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, SF));
        tick(0, 0, 1, 1, 1, 0, 0);
        e = exp_q.pop_front(); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL idle_hold: got %h expected %h", obs(), e); end
    endtask

    task automatic test_hits();
        exp_q.push_back(mk(1, 0, 0, 0, 0, SF));
        tick(0, 1, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL start_load: got %h expected %h", obs(), e); end
        for (int f = 1; f <= 3; f++) begin
            for (int c = 0; c < 5; c++) tick(0, 0, 0, 1, 1, 0, 0);
            exp_q.push_back(mk(1, 0, 0, f, f * HS, SF));
            tick(0, 0, 1, 0, 0, 0, 0);
            e = exp_q.pop_front(); n_tests++;
            if (obs() !== e) begin n_fail++; $display("FAIL hits_frame%0d: got %h expected %h", f, obs(), e); end
        end
    endtask

    task automatic test_clear();
        tick(0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= AMT; k++) begin
            tick(0, 0, 0, 1, 1, 0, 0);
            tick(0, 0, 0, 0, 0, 0, 0);
            if (k < AMT) exp_q.push_back(mk(1, 0, 0, k, k * HS, SF));
            else         exp_q.push_back(mk(0, 1, 1, AMT, AMT * HS, SF));
            tick(0, 0, 1, 0, 0, 0, 0);
            e = exp_q.pop_front(); n_tests++;
            if (obs() !== e) begin n_fail++; $display("FAIL clear_eval%0d: got %h expected %h", k, obs(), e); end
        end
        exp_q.push_back(mk(0, 0, 1, AMT, AMT * HS, SF));
        tick(0, 0, 0, 1, 1, 0, 0);
        e = exp_q.pop_front(); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL clear_done_once: got %h expected %h", obs(), e); end
        exp_q.push_back(mk(0, 0, 1, AMT, AMT * HS, SF));
        tick(0, 0, 1, 1, 1, 0, 0);
        e = exp_q.pop_front(); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL clear_sticky: got %h expected %h", obs(), e); end
    endtask

    task automatic test_fail();
        tick(0, 1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 1, 1, 0);
        exp_q.push_back(mk(0, 1, 0, 0, 0, SF));
        tick(0, 0, 1, 0, 0, 0, 0);
        e = exp_q.pop_front(); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL fail_enter: got %h expected %h", obs(), e); end
        exp_q.push_back(mk(0, 0, 0, 0, 0, SF));
        tick(0, 0, 0, 1, 1, 0, 0);
        e = exp_q.pop_front(); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL fail_done_once: got %h expected %h", obs(), e); end
        exp_q.push_back(mk(0, 0, 0, 0, 0, SF));
        tick(0, 0, 1, 1, 1, 0, 0);
        e = exp_q.pop_front(); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL fail_sticky: got %h expected %h", obs(), e); end
    endtask

    task automatic test_timeout();
        tick(0, 1, 0, 0, 0, 0, 0);
        for (int f = 1; f <= SF; f++) begin
            if (f < SF) exp_q.push_back(mk(1, 0, 0, 0, 0, SF - f));
            else        exp_q.push_back(mk(0, 1, 1, 0, 0, 0));
            tick(0, 0, 1, 0, 0, 0, 0);
            e = exp_q.pop_front(); n_tests++;
            if (obs() !== e) begin n_fail++; $display("FAIL timeout_frame%0d: got %h expected %h", f, obs(), e); end
        end
    endtask

    task automatic test_restart();
        tick(0, 1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 1, 0);
        tick(0, 0, 1, 0, 0, 0, 0);
        exp_q.push_back(mk(1, 0, 0, 0, 0, SF));
        tick(0, 1, 1, 1, 1, 0, 0);
        e = exp_q.pop_front(); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL restart_load: got %h expected %h", obs(), e); end
        exp_q.push_back(mk(1, 0, 0, 0, 0, SF - 1));
        tick(0, 0, 1, 0, 0, 0, 0);
        e = exp_q.pop_front(); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL restart_latch_clear: got %h expected %h", obs(), e); end
        tick(0, 0, 0, 1, 1, 0, 0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, SF));
        tick(1, 1, 1, 1, 1, 0, 0);
        e = exp_q.pop_front(); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_mid_stage: got %h expected %h", obs(), e); end
        exp_q.push_back(mk(0, 0, 0, 0, 0, SF));
        tick(0, 0, 1, 0, 0, 0, 0);
        e = exp_q.pop_front(); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_then_idle: got %h expected %h", obs(), e); end
    endtask

    task automatic test_back_to_back();
        tick(0, 1, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(1, 0, 0, 0, 0, SF - 1));
        tick(0, 0, 1, 1, 1, 0, 0);
        e = exp_q.pop_front(); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL b2b_sof_hit_eval: got %h expected %h", obs(), e); end
        exp_q.push_back(mk(1, 0, 0, 1, HS, SF - 1));
        tick(0, 0, 1, 1, 0, 1, 0);
        e = exp_q.pop_front(); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL b2b_hit_next_frame: got %h expected %h", obs(), e); end
        exp_q.push_back(mk(0, 1, 0, 1, HS, SF - 1));
        tick(0, 0, 1, 0, 0, 0, 0);
        e = exp_q.pop_front(); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL b2b_sof_dead_fail: got %h expected %h", obs(), e); end
    endtask

    initial begin
        test_reset();
        test_collision_idle();
        test_hits();
        test_clear();
        test_fail();
        test_timeout();
        test_restart();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
